// File: rtl/block_scanner_if.sv
// Purpose: bundles the beam position, board RAM read port and shader outputs of the block scanner.
// Latency: none (signal bundle only).
// Backpressure: none; the pixel strobe pix_en paces every consumer.
// Ports (modport slave = scanner side, master = timing generator / RAM / shader side):
//   pix_en, x, y, de  beam strobe, position and display enable
//   ram_addr, ram_rd  board RAM read request; ram_data returns one strobe later
//   block_x, block_y, cell_color, draw_block, de_out  shader-facing results
interface block_scanner_if;
    logic        pix_en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        de;
    logic [7:0]  ram_addr;
    logic        ram_rd;
    logic [11:0] ram_data;
    logic [5:0]  block_x;
    logic [5:0]  block_y;
    logic [11:0] cell_color;
    logic        draw_block;
    logic        de_out;

    modport master (
        output pix_en, x, y, de, ram_data,
        input  ram_addr, ram_rd, block_x, block_y, cell_color, draw_block, de_out
    );

    modport slave (
        input  pix_en, x, y, de, ram_data,
        output ram_addr, ram_rd, block_x, block_y, cell_color, draw_block, de_out
    );
endinterface

// File: rtl/block_scanner.sv
// Purpose: maps the beam position onto a board cell and intra-cell offset with counters, fetches the cell colour.
// Latency: 2 pix_en strobes from (x, y, de) sample to block_x/block_y/cell_color/draw_block/de_out.
// Backpressure: none; everything advances only on pix_en and holds while it is low.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the pixel strobe/position,
//        the board RAM read port (ram_addr, ram_rd, ram_data) and the shader outputs.
module block_scanner #(
    parameter int          BLOCK_W  = 26,
    parameter int          BLOCK_H  = 32,
    parameter int          COLS     = 10,
    parameter int          ROWS     = 15,
    parameter int          ORIGIN_X = 190,
    parameter int          ORIGIN_Y = 0,
    parameter int          H_LAST   = 639,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic            clk,
    input  logic            rst_n,
    block_scanner_if.slave  bus
);
    localparam int              CW       = $clog2(COLS + 1);
    localparam int              RW       = $clog2(ROWS + 1);
    localparam logic [9:0]      X_ORG    = 10'(ORIGIN_X);
    localparam logic [9:0]      X_LAST   = 10'(H_LAST);
    localparam logic [9:0]      Y_PRE    = 10'((ORIGIN_Y == 0) ? 0 : ORIGIN_Y - 1);
    localparam logic [5:0]      SX_LAST  = 6'(BLOCK_W - 1);
    localparam logic [5:0]      SY_LAST  = 6'(BLOCK_H - 1);
    localparam logic [CW-1:0]   COL_END  = CW'(COLS);
    localparam logic [RW-1:0]   ROW_END  = RW'(ROWS);

    if (COLS * ROWS > 256) begin : g_bad_board
        $error("block_scanner: COLS*ROWS must not exceed 256 (8-bit RAM address)");
    end
    if (BLOCK_W < 2 || BLOCK_W > 64 || BLOCK_H < 2 || BLOCK_H > 64) begin : g_bad_cell
        $error("block_scanner: BLOCK_W and BLOCK_H must be in 2..64 (6-bit offsets)");
    end

    // Stage 1: position counters (hold the values of the pixel just sampled) and RAM address.
    logic [5:0]    sub_x_q, sub_x_d;
    logic [CW-1:0] col_q, col_d;
    logic [5:0]    sub_y_q, sub_y_d;
    logic [RW-1:0] row_q, row_d;
    logic          synced_q, synced_d;
    logic          in_board1_q, in_board1_d;
    logic          de1_q, de1_d;
    logic [7:0]    ram_addr_q, ram_addr_d;
    // Stage 2: aligned with the RAM read data.
    logic [5:0]    block_x_q, block_x_d;
    logic [5:0]    block_y_q, block_y_d;
    logic          de_out_q, de_out_d;
    logic          in_board2_q, in_board2_d;

    logic          frame_start;
    logic          cur_synced;
    logic          cur_in_board;

    always_comb begin
        sub_x_d      = sub_x_q;
        col_d        = col_q;
        sub_y_d      = sub_y_q;
        row_d        = row_q;
        synced_d     = synced_q;
        in_board1_d  = in_board1_q;
        de1_d        = de1_q;
        ram_addr_d   = ram_addr_q;
        block_x_d    = block_x_q;
        block_y_d    = block_y_q;
        de_out_d     = de_out_q;
        in_board2_d  = in_board2_q;
        frame_start  = (bus.x == 10'd0) && (bus.y == 10'd0);
        cur_synced   = 1'b0;
        cur_in_board = 1'b0;

        if (bus.pix_en) begin
            // Horizontal: restart at the board's left edge, otherwise count until col parks at COLS.
            if (bus.x == X_ORG) begin
                sub_x_d = '0;
                col_d   = '0;
            end else if (col_q < COL_END) begin
                if (sub_x_q == SX_LAST) begin
                    sub_x_d = '0;
                    col_d   = col_q + CW'(1);
                end else begin
                    sub_x_d = sub_x_q + 6'd1;
                end
            end

            // Vertical: a board at line 0 restarts on the frame-start pixel; otherwise it restarts
            // at the end of the line just above the board. Lines advance on the last active pixel.
            if ((ORIGIN_Y == 0) ? frame_start : ((bus.x == X_LAST) && (bus.y == Y_PRE))) begin
                sub_y_d = '0;
                row_d   = '0;
            end else if ((bus.x == X_LAST) && (row_q < ROW_END)) begin
                if (sub_y_q == SY_LAST) begin
                    sub_y_d = '0;
                    row_d   = row_q + RW'(1);
                end else begin
                    sub_y_d = sub_y_q + 6'd1;
                end
            end

            cur_synced   = synced_q | frame_start;
            synced_d     = cur_synced;
            cur_in_board = cur_synced & bus.de & (col_d < COL_END) & (row_d < ROW_END);
            in_board1_d  = cur_in_board;
            de1_d        = bus.de;
            ram_addr_d   = cur_in_board ? 8'(int'(row_d) * COLS + int'(col_d)) : 8'd0;

            block_x_d    = in_board1_q ? sub_x_q : 6'd0;
            block_y_d    = in_board1_q ? sub_y_q : 6'd0;
            de_out_d     = de1_q;
            in_board2_d  = in_board1_q;
        end
    end

    // col/row reset to their parked (off-board) values so nothing is drawn before the first
    // left-edge / frame-start restart, even if the frame start arrives right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_x_q     <= '0;
            col_q       <= COL_END;
            sub_y_q     <= '0;
            row_q       <= ROW_END;
            synced_q    <= 1'b0;
            in_board1_q <= 1'b0;
            de1_q       <= 1'b0;
            ram_addr_q  <= 8'd0;
            block_x_q   <= 6'd0;
            block_y_q   <= 6'd0;
            de_out_q    <= 1'b0;
            in_board2_q <= 1'b0;
        end else begin
            sub_x_q     <= sub_x_d;
            col_q       <= col_d;
            sub_y_q     <= sub_y_d;
            row_q       <= row_d;
            synced_q    <= synced_d;
            in_board1_q <= in_board1_d;
            de1_q       <= de1_d;
            ram_addr_q  <= ram_addr_d;
            block_x_q   <= block_x_d;
            block_y_q   <= block_y_d;
            de_out_q    <= de_out_d;
            in_board2_q <= in_board2_d;
        end
    end

    assign bus.ram_rd     = bus.pix_en;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.block_x    = block_x_q;
    assign bus.block_y    = block_y_q;
    assign bus.de_out     = de_out_q;
    assign bus.draw_block = in_board2_q & (bus.ram_data != 12'd0);
    assign bus.cell_color = bus.draw_block ? bus.ram_data : BG_COLOR;
endmodule
